i2s_clock_follower: RTL and testbench

- Slave-side counterpart of the I2S clock generator. Used when an external master (codec, second FPGA) drives SCK/WS.
- Brings the external sck and ws into the ck domain through synchronisers. Detects SCK rising edges and tracks position within the 64-bit L/R frame.
- Produces the same en/sck/ws/frame_posn interface that downstream I2S rx/tx blocks already consume, plus lock and error status.

---
 rtl/i2s_clock_follower_pkg.sv | 21 ++
 rtl/i2s_clock_follower_sync2.sv | 36 +++
 rtl/i2s_clock_follower.sv | 157 +++++++++++++++
 tb/tb_i2s_clock_follower.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_clock_follower_pkg.sv
// Shared I2S constants and the clock-follower state encoding.
// The frame constants are common to the clock generator, the follower and
// the rx/tx blocks, so they live here rather than in any one module.
package i2s_clock_follower_pkg;

    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_HALF_BITS  = 32;
    localparam int I2S_POSN_W     = 6;

    // Last bit of the frame and last bit of the left half: the pre-update
    // positions at which a well-formed WS fall / WS rise is sampled.
    localparam logic [I2S_POSN_W-1:0] POSN_LAST      = I2S_POSN_W'(I2S_FRAME_BITS - 1);
    localparam logic [I2S_POSN_W-1:0] POSN_HALF_LAST = I2S_POSN_W'(I2S_HALF_BITS - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_LOCKED = 2'd2
    } follower_state_e;

endpackage

// File: rtl/i2s_clock_follower_sync2.sv
// Generic two-flop synchroniser for a single asynchronous input.
// Ports:
//   ck    - destination clock
//   rst   - asynchronous reset, active-high (both flops clear to 0)
//   d_in  - asynchronous input
//   d_out - synchronised output (second flop)
module i2s_clock_follower_sync2 (
    input  logic ck,
    input  logic rst,
    input  logic d_in,
    output logic d_out
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value; blocking here would collapse the chain into one flop.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/i2s_clock_follower.sv
// I2S clock follower: slave-side replacement for the I2S clock generator.
// Synchronises an externally driven SCK/WS pair into the ck domain, pulses
// en once per SCK rising edge, tracks the bit position in the 64-bit frame
// and verifies frame structure before asserting locked.
// Ports:
//   ck, rst     - system clock, asynchronous active-high reset
//   sck_in      - external bit clock (asynchronous)
//   ws_in       - external word select (asynchronous)
//   en          - one-ck pulse per detected SCK rising edge
//   sck         - synchronised sck_in
//   ws          - WS sampled at the last SCK rising edge
//   frame_posn  - bit position, 0 = first bit clock after WS falls
//   locked      - frame structure verified
//   error       - one-ck pulse on framing violation or timeout while locked
module i2s_clock_follower
    import i2s_clock_follower_pkg::*;
#(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  sck_in,
    input  logic                  ws_in,
    output logic                  en,
    output logic                  sck,
    output logic                  ws,
    output logic [I2S_POSN_W-1:0] frame_posn,
    output logic                  locked,
    output logic                  error
);

    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int GOOD_W = 4;
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_FRAMES);

    logic sck_sync, ws_sync;

    i2s_clock_follower_sync2 u_sync_sck (.ck(ck), .rst(rst), .d_in(sck_in), .d_out(sck_sync));
    i2s_clock_follower_sync2 u_sync_ws  (.ck(ck), .rst(rst), .d_in(ws_in),  .d_out(ws_sync));

    logic                  sck_prev_d, sck_prev_q;
    logic                  en_d, en_q;
    logic                  ws_d, ws_q;
    logic [I2S_POSN_W-1:0] posn_d, posn_q;
    logic [TMO_W-1:0]      tmo_d, tmo_q;
    logic [GOOD_W-1:0]     good_d, good_q;
    logic                  locked_d, locked_q;
    logic                  error_d, error_q;
    follower_state_e       state_d, state_q;

    logic rise, ws_fall, ws_rise;
    logic [GOOD_W-1:0] good_inc;

    // WS edges compare the value captured at the previous SCK rise with the
    // value about to be captured; they are only meaningful when rise is high.
    assign rise     = sck_sync & ~sck_prev_q;
    assign ws_fall  = ws_q & ~ws_sync;
    assign ws_rise  = ~ws_q & ws_sync;
    assign good_inc = good_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sck_prev_d = sck_sync;
        en_d       = rise;
        ws_d       = ws_q;
        posn_d     = posn_q;
        tmo_d      = tmo_q;
        good_d     = good_q;
        locked_d   = locked_q;
        error_d    = 1'b0;
        state_d    = state_q;

        if (rise) begin
            ws_d   = ws_sync;
            tmo_d  = '0;
            posn_d = ws_fall ? '0 : posn_q + 1'b1;

            unique case (state_q)
                ST_HUNT: begin
                    good_d   = '0;
                    locked_d = 1'b0;
                    if (ws_fall) state_d = ST_COUNT;
                end
                ST_COUNT: begin
                    if (ws_fall) begin
                        if (posn_q == POSN_LAST) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_CNT) begin
                                state_d  = ST_LOCKED;
                                locked_d = 1'b1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end else if (ws_rise && posn_q != POSN_HALF_LAST) begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if ((ws_fall && posn_q != POSN_LAST) ||
                        (ws_rise && posn_q != POSN_HALF_LAST)) begin
                        error_d  = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        state_d  = ST_COUNT;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else if (tmo_q != TMO_MAX) begin
            // Saturating counter: the timeout action fires once, on the
            // cycle the count reaches TIMEOUT.
            tmo_d = tmo_q + 1'b1;
            if (tmo_d == TMO_MAX) begin
                state_d  = ST_HUNT;
                good_d   = '0;
                locked_d = 1'b0;
                error_d  = locked_q;
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            sck_prev_q <= 1'b0;
            en_q       <= 1'b0;
            ws_q       <= 1'b0;
            posn_q     <= '0;
            tmo_q      <= '0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            state_q    <= ST_HUNT;
        end else begin
            sck_prev_q <= sck_prev_d;
            en_q       <= en_d;
            ws_q       <= ws_d;
            posn_q     <= posn_d;
            tmo_q      <= tmo_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            state_q    <= state_d;
        end
    end

    assign en         = en_q;
    assign sck        = sck_sync;
    assign ws         = ws_q;
    assign frame_posn = posn_q;
    assign locked     = locked_q;
    assign error      = error_q;

endmodule

// File: tb/tb_i2s_clock_follower.sv
// Self-checking bench for i2s_clock_follower (LOCK_FRAMES=2, TIMEOUT=256).
// Each driven SCK rise pushes the expected en cycle, ws and frame_posn onto
// a scoreboard; a monitor pops and compares on every en pulse. Lock, error
// and reset behaviour are checked at directed points in the main sequence.
module tb_i2s_clock_follower;

    logic       ck;
    logic       rst;
    logic       sck_in;
    logic       ws_in;
    logic       en;
    logic       sck;
    logic       ws;
    logic [5:0] frame_posn;
    logic       locked;
    logic       error;

    i2s_clock_follower #(
        .LOCK_FRAMES(2),
        .TIMEOUT    (256)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .sck_in    (sck_in),
        .ws_in     (ws_in),
        .en        (en),
        .sck       (sck),
        .ws        (ws),
        .frame_posn(frame_posn),
        .locked    (locked),
        .error     (error)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct {
        int         cyc;
        logic       ws;
        logic [5:0] posn;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor-derived observations
    int   err_cycles    = 0;
    int   last_err_cyc  = -1;
    int   lock_rise_cyc = -1;
    logic locked_seen   = 1'b0;

    // Stimulus-side model of the frame
    logic       m_ws          = 1'b0;
    logic [5:0] m_posn        = 6'd0;
    int         last_en       = -1;
    int         last_fall_en  = -1;
    int         exp_err       = 0;
    int         rise_err_cyc  = 0;

    always @(posedge ck) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge ck) begin
        if (!rst) begin
            if (en) begin
                check("en_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("en_cycle", cyc, e.cyc);
                    check("ws_at_en", 32'(ws), 32'(e.ws));
                    check("posn_at_en", 32'(frame_posn), 32'(e.posn));
                end
            end
            if (error) begin
                err_cycles++;
                last_err_cyc = cyc;
            end
            if (locked && !locked_seen) lock_rise_cyc = cyc;
        end
        locked_seen = locked;
    end

    // One SCK bit: WS changes with SCK low, SCK rises 12 ck later at a
    // sub-cycle phase offset d, then SCK stays high for the rest of the bit.
    task automatic send_bit(input logic wsv, input int d);
        logic fall;
        @(negedge ck);
        #(d);
        sck_in = 1'b0;
        ws_in  = wsv;
        repeat (12) @(negedge ck);
        #(d);
        sck_in = 1'b1;
        fall   = m_ws & ~wsv;
        m_posn = fall ? 6'd0 : m_posn + 6'd1;
        m_ws   = wsv;
        sb.push_back('{cyc: cyc + 3, ws: wsv, posn: m_posn});
        last_en = cyc + 3;
        if (fall) last_fall_en = cyc + 3;
        repeat (11) @(negedge ck);
    endtask

    task automatic send_frame(input int lo, input int hi);
        for (int i = 0; i < lo; i++) send_bit(1'b0, i % 5);
        for (int i = 0; i < hi; i++) send_bit(1'b1, (lo + i) % 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no completion, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        sck_in = 1'b0;
        ws_in  = 1'b0;
        repeat (3) @(negedge ck);

        // Reset state
        check("rst_en",     32'(en), 0);
        check("rst_sck",    32'(sck), 0);
        check("rst_ws",     32'(ws), 0);
        check("rst_posn",   32'(frame_posn), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_error",  32'(error), 0);
        rst = 1'b0;
        repeat (2) @(negedge ck);

        // Standard frames: lock on the third WS fall (start of frame 4)
        send_frame(32, 32);
        send_frame(32, 32);
        send_frame(32, 32);
        check("std_not_locked_yet", 32'(locked), 0);
        send_frame(32, 32);
        check("std_locked", 32'(locked), 1);
        check("std_lock_cycle", lock_rise_cyc, last_fall_en);
        check("std_no_error", err_cycles, exp_err);

        // Short frame: WS falls at frame_posn 62 while locked
        send_frame(32, 31);
        send_frame(32, 32);
        exp_err++;
        check("short_err_count", err_cycles, exp_err);
        check("short_err_cycle", last_err_cyc, last_fall_en);
        check("short_unlocked", 32'(locked), 0);
        send_frame(32, 32);
        check("short_still_unlocked", 32'(locked), 0);
        send_frame(32, 32);
        check("short_relocked", 32'(locked), 1);
        check("short_relock_cycle", lock_rise_cyc, last_fall_en);

        // Misplaced WS rise at frame_posn 30 while locked
        for (int i = 0; i < 31; i++) send_bit(1'b0, i % 5);
        send_bit(1'b1, 1);
        rise_err_cyc = last_en;
        exp_err++;
        check("rise_err_count", err_cycles, exp_err);
        check("rise_err_cycle", last_err_cyc, rise_err_cyc);
        check("rise_unlocked", 32'(locked), 0);
        for (int i = 0; i < 32; i++) send_bit(1'b1, i % 5);
        send_frame(32, 32);
        send_frame(32, 32);
        check("rise_relocked", 32'(locked), 1);

        // Clock stop: SCK held low for 300 ck while locked
        @(negedge ck);
        sck_in = 1'b0;
        repeat (300) @(negedge ck);
        exp_err++;
        check("tmo_err_count", err_cycles, exp_err);
        check("tmo_err_cycle", last_err_cyc, last_en + 256);
        check("tmo_unlocked", 32'(locked), 0);
        send_frame(32, 32);
        send_frame(32, 32);
        check("tmo_not_relocked_yet", 32'(locked), 0);
        send_frame(32, 32);
        check("tmo_relocked", 32'(locked), 1);
        check("tmo_relock_cycle", lock_rise_cyc, last_fall_en);

        // Async reset mid-frame at frame_posn 40
        send_frame(32, 9);
        check("pre_rst_posn", 32'(frame_posn), 40);
        check("pre_rst_locked", 32'(locked), 1);
        check("pre_rst_sb_empty", 32'(sb.size()), 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_en",     32'(en), 0);
        check("mid_rst_sck",    32'(sck), 0);
        check("mid_rst_ws",     32'(ws), 0);
        check("mid_rst_posn",   32'(frame_posn), 0);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_error",  32'(error), 0);
        sck_in = 1'b0;
        ws_in  = 1'b0;
        m_ws   = 1'b0;
        m_posn = 6'd0;
        repeat (3) @(negedge ck);
        rst = 1'b0;
        send_frame(32, 32);
        send_frame(32, 32);
        send_frame(32, 32);
        check("post_rst_not_locked", 32'(locked), 0);
        send_frame(32, 32);
        check("post_rst_locked", 32'(locked), 1);
        check("post_rst_lock_cycle", lock_rise_cyc, last_fall_en);
        check("final_err_count", err_cycles, exp_err);

        repeat (5) @(negedge ck);
        check("final_sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
